// File: rtl/lbist_pkg.sv
// LBIST register map, CTRL/STATUS bit positions and session FSM states.
// Both the Wishbone session initiator and the LBIST register block import this.
package lbist_pkg;

  localparam logic [1:0] LBIST_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] LBIST_ADDR_CFG    = 2'd1;
  localparam logic [1:0] LBIST_ADDR_STATUS = 2'd2;
  localparam logic [1:0] LBIST_ADDR_SIG    = 2'd3;

  localparam int LBIST_CTRL_SRST   = 0;
  localparam int LBIST_CTRL_START  = 1;
  localparam int LBIST_STATUS_DONE = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_SRST,
    ST_W_REL,
    ST_W_CFG,
    ST_W_GO,
    ST_POLL,
    ST_GAP,
    ST_R_SIG,
    ST_CMP
  } seq_state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } wb_req_t;

  function automatic logic [31:0] ctrl_word(input logic srst, input logic start);
    logic [31:0] w;
    w                   = '0;
    w[LBIST_CTRL_SRST]  = srst;
    w[LBIST_CTRL_START] = start;
    return w;
  endfunction

endpackage

// File: rtl/lbist_wb_xfer.sv
// Single Wishbone transfer engine: registered cs/addr/wr/wdata held until ack/err; done/err are combinational on that edge.
// Accepts a request only while idle, so cs is always low for at least one cycle between transfers.
module lbist_wb_xfer
  import lbist_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  wb_req_t     i_req_dat,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_wbm_cs,
  output logic [1:0]  o_wbm_addr,
  output logic        o_wbm_wr,
  output logic [31:0] o_wbm_wdata,
  output logic [3:0]  o_wbm_be,
  input  logic [31:0] i_wbm_rdata,
  input  logic        i_wbm_ack,
  input  logic        i_wbm_err
);

  logic    r_cs;
  wb_req_t r_req;

  assign o_req_rdy = ~r_cs;
  // err wins when the target raises ack and err together
  assign o_err     = r_cs & i_wbm_err;
  assign o_done    = r_cs & i_wbm_ack & ~i_wbm_err;
  assign o_rdata   = i_wbm_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cs  <= 1'b0;
      r_req <= '0;
    end else if (r_cs) begin
      if (i_wbm_ack | i_wbm_err) r_cs <= 1'b0;
    end else if (i_req_vld) begin
      r_cs  <= 1'b1;
      r_req <= i_req_dat;
    end
  end

  assign o_wbm_cs    = r_cs;
  assign o_wbm_addr  = r_req.addr;
  assign o_wbm_wr    = r_req.wr;
  assign o_wbm_wdata = r_req.wdata;
  assign o_wbm_be    = 4'hF;

endmodule

// File: rtl/lbist_wb_seq.sv
// Autonomous LBIST session initiator: soft-reset, configure, start, poll STATUS, read SIG, compare to golden.
// seq_start is taken only when idle; define LBIST_SEQ_TIMEOUT_EN to bound polling to POLL_MAX STATUS reads.
module lbist_wb_seq
  import lbist_pkg::*;
#(
  parameter int POLL_GAP = 16,
  parameter int POLL_MAX = 4096
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        seq_start,
  input  logic [15:0] cfg_pat,
  input  logic [15:0] cfg_depth,
  input  logic [31:0] cfg_gold_sig,
  output logic        wbm_cs,
  output logic [1:0]  wbm_addr,
  output logic        wbm_wr,
  output logic [31:0] wbm_wdata,
  output logic [3:0]  wbm_be,
  input  logic [31:0] wbm_rdata,
  input  logic        wbm_ack,
  input  logic        wbm_err,
  output logic        seq_busy,
  output logic        seq_done,
  output logic        seq_pass,
  output logic        seq_fail,
  output logic        seq_err,
  output logic [31:0] seq_sig
);

  localparam int GW = $clog2(POLL_GAP + 1);

  seq_state_t  r_state, w_next;
  logic        w_req_vld, w_req_rdy, w_xdone, w_xerr, w_timeout, w_accept;
  wb_req_t     w_req_dat;
  logic [31:0] w_rdata;
  logic        r_launched;
  logic [GW-1:0] r_gap_cnt;
  logic [15:0] r_pat, r_depth;
  logic [31:0] r_gold, r_sig;
  logic        r_done, r_pass, r_fail, r_err;

  assign w_accept = (r_state == ST_IDLE) & seq_start;

  lbist_wb_xfer u_xfer (
    .i_clk       (wb_clk),
    .i_rst_n     (wb_rst_n),
    .i_req_vld   (w_req_vld),
    .o_req_rdy   (w_req_rdy),
    .i_req_dat   (w_req_dat),
    .o_done      (w_xdone),
    .o_err       (w_xerr),
    .o_rdata     (w_rdata),
    .o_wbm_cs    (wbm_cs),
    .o_wbm_addr  (wbm_addr),
    .o_wbm_wr    (wbm_wr),
    .o_wbm_wdata (wbm_wdata),
    .o_wbm_be    (wbm_be),
    .i_wbm_rdata (wbm_rdata),
    .i_wbm_ack   (wbm_ack),
    .i_wbm_err   (wbm_err)
  );

`ifdef LBIST_SEQ_TIMEOUT_EN
  localparam int PW = $clog2(POLL_MAX + 1);
  logic [PW-1:0] r_poll_cnt;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n)                   r_poll_cnt <= '0;
    else if (w_accept)               r_poll_cnt <= '0;
    else if ((r_state == ST_POLL) && w_xdone && (r_poll_cnt != PW'(POLL_MAX)))
                                     r_poll_cnt <= r_poll_cnt + 1'b1;
  end

  assign w_timeout = (r_state == ST_POLL) & w_xdone & ~w_rdata[LBIST_STATUS_DONE] &
                     (r_poll_cnt == PW'(POLL_MAX - 1));
`else
  logic w_unused_poll_max;
  assign w_unused_poll_max = (POLL_MAX > 0);
  assign w_timeout         = 1'b0;
`endif

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  // Each bus state issues exactly one transfer; r_launched blocks a reissue while it is in flight.
  always_comb begin
    w_next    = r_state;
    w_req_vld = 1'b0;
    w_req_dat = '{wr: 1'b1, addr: LBIST_ADDR_CTRL, wdata: 32'd0};
    case (r_state)
      ST_IDLE: begin
        w_req_vld       = seq_start;
        w_req_dat.wdata = ctrl_word(1'b1, 1'b0);
        if (seq_start) w_next = ST_W_SRST;
      end
      ST_W_SRST: begin
        w_req_vld       = ~r_launched;
        w_req_dat.wdata = ctrl_word(1'b1, 1'b0);
        if (w_xdone) w_next = ST_W_REL;
      end
      ST_W_REL: begin
        w_req_vld       = ~r_launched;
        w_req_dat.wdata = ctrl_word(1'b0, 1'b0);
        if (w_xdone) w_next = ST_W_CFG;
      end
      ST_W_CFG: begin
        w_req_vld      = ~r_launched;
        w_req_dat.addr = LBIST_ADDR_CFG;
        w_req_dat.wdata = {r_depth, r_pat};
        if (w_xdone) w_next = ST_W_GO;
      end
      ST_W_GO: begin
        w_req_vld       = ~r_launched;
        w_req_dat.wdata = ctrl_word(1'b0, 1'b1);
        if (w_xdone) w_next = ST_POLL;
      end
      ST_POLL: begin
        w_req_vld      = ~r_launched;
        w_req_dat.wr   = 1'b0;
        w_req_dat.addr = LBIST_ADDR_STATUS;
        if (w_timeout)   w_next = ST_IDLE;
        else if (w_xdone) w_next = w_rdata[LBIST_STATUS_DONE] ? ST_R_SIG : ST_GAP;
      end
      ST_GAP: begin
        if (r_gap_cnt == GW'(POLL_GAP - 1)) w_next = ST_POLL;
      end
      ST_R_SIG: begin
        w_req_vld      = ~r_launched;
        w_req_dat.wr   = 1'b0;
        w_req_dat.addr = LBIST_ADDR_SIG;
        if (w_xdone) w_next = ST_CMP;
      end
      ST_CMP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (w_xerr) w_next = ST_IDLE;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n)                    r_launched <= 1'b0;
    else if (w_xdone | w_xerr)        r_launched <= 1'b0;
    else if (w_req_vld & w_req_rdy)   r_launched <= 1'b1;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n)                       r_gap_cnt <= '0;
    else if (r_state != ST_GAP)          r_gap_cnt <= '0;
    else if (r_gap_cnt != GW'(POLL_GAP)) r_gap_cnt <= r_gap_cnt + 1'b1;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_err   <= 1'b0;
      r_sig   <= '0;
      r_pat   <= '0;
      r_depth <= '0;
      r_gold  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_pass  <= 1'b0;
        r_fail  <= 1'b0;
        r_err   <= 1'b0;
        r_pat   <= cfg_pat;
        r_depth <= cfg_depth;
        r_gold  <= cfg_gold_sig;
      end
      if (w_xerr | w_timeout) begin
        r_err  <= 1'b1;
        r_done <= 1'b1;
      end
      if ((r_state == ST_R_SIG) && w_xdone) r_sig <= w_rdata;
      if (r_state == ST_CMP) begin
        r_done <= 1'b1;
        r_pass <= (r_sig == r_gold);
        r_fail <= (r_sig != r_gold);
      end
    end
  end

  assign seq_busy = (r_state != ST_IDLE);
  assign seq_done = r_done;
  assign seq_pass = r_pass;
  assign seq_fail = r_fail;
  assign seq_err  = r_err;
  assign seq_sig  = r_sig;

endmodule
